// File: rtl/timeshared_pkg.sv
// timeshared_pkg: frame-state type, error-counter width and slot-width helper
// shared by the time-shared demultiplexer/deserialiser.
package timeshared_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_e;

  localparam int ERRCNT_W = 8;

  // Width of the slot counter for a frame of 2*word_w cycles.
  function automatic int slot_width(input int word_w);
    return $clog2(2 * word_w);
  endfunction

endpackage

// File: rtl/ts_shift_collect.sv
// ts_shift_collect: WORD_W-bit LSB-first collector. A new bit enters at the
// MSB and moves toward bit 0, so after WORD_W shifts the first bit sits at
// bit 0. The clear restarts the word, and the incoming bit can be shifted in
// on the same edge. data_next is the value the register will take on the
// next edge. The owner uses it to latch a word on the edge that completes it.
module ts_shift_collect #(
  parameter int WORD_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic              bit_in,
  output logic [WORD_W-1:0] data_next
);

  logic [WORD_W-1:0] data_q;
  logic [WORD_W-1:0] data_d;
  logic [WORD_W-1:0] base_s;

  // Next contents: optional restart, then an optional right shift of the new bit.
  always_comb begin
    base_s = clr ? {WORD_W{1'b0}} : data_q;
    if (en) begin
      data_d = {bit_in, base_s[WORD_W-1:1]};
    end else begin
      data_d = base_s;
    end
  end

  assign data_next = data_d;

  // Collector register, cleared asynchronously by the active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= {WORD_W{1'b0}};
    end else begin
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/timeshared_demux_deser.sv
// timeshared_demux_deser: splits the interleaved serial line into two channels.
// Even slots carry channel 1 and odd slots carry channel 2. Each channel is
// deserialised into WORD_W-bit words. A HUNT/LOCK machine tracks frame sync.
// Optional macro DEMUX_ERRCNT_EN adds a saturating 8-bit sync-error counter
// on output port err_count.
module timeshared_demux_deser
  import timeshared_pkg::*;
#(
  parameter int WORD_W        = 4,
  parameter int SYNC_MISS_MAX = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           din,
  input  logic                           sync,
  output logic [WORD_W-1:0]              word1,
  output logic [WORD_W-1:0]              word2,
  output logic                           word_valid,
  output logic                           lock,
  output logic [slot_width(WORD_W)-1:0]  slot,
  output logic                           sync_err
`ifdef DEMUX_ERRCNT_EN
  ,
  output logic [ERRCNT_W-1:0]            err_count
`endif
);

  localparam int SLOT_W = slot_width(WORD_W);
  localparam int MISS_W = $clog2(SYNC_MISS_MAX + 1);
  localparam logic [SLOT_W-1:0] SLOT_ZERO = {SLOT_W{1'b0}};
  localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(2 * WORD_W - 1);
  localparam logic [MISS_W-1:0] MISS_ZERO = {MISS_W{1'b0}};
  localparam logic [MISS_W-1:0] MISS_ONE  = MISS_W'(1);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(SYNC_MISS_MAX - 1);

  state_e              state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [MISS_W-1:0]   miss_q, miss_d;
  logic [WORD_W-1:0]   word1_q, word1_d;
  logic [WORD_W-1:0]   word2_q, word2_d;
  logic                word_valid_q, word_valid_d;
  logic                lock_q, lock_d;
  logic                sync_err_q, sync_err_d;
  logic                en1_s, en2_s, clr_s;
  logic [WORD_W-1:0]   ch1_next_s, ch2_next_s;
  logic                miss_hit_s;

  // A further sync error now would reach the loss-of-lock limit.
  assign miss_hit_s = (miss_q >= MISS_LAST);

  // Frame tracking: state, slot, miss counter, collector control and word latch.
  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    miss_d       = miss_q;
    word1_d      = word1_q;
    word2_d      = word2_q;
    word_valid_d = 1'b0;
    sync_err_d   = 1'b0;
    en1_s        = 1'b0;
    en2_s        = 1'b0;
    clr_s        = 1'b0;
    case (state_q)
      HUNT: begin
        if (sync) begin
          state_d = LOCK;
          slot_d  = SLOT_ONE;
          miss_d  = MISS_ZERO;
          clr_s   = 1'b1;
          en1_s   = 1'b1;
        end else begin
          slot_d = SLOT_ZERO;
        end
      end
      LOCK: begin
        if ((slot_q == SLOT_ZERO) != sync) begin
          // Missing sync at slot 0 or misplaced sync elsewhere.
          sync_err_d = 1'b1;
          if (miss_hit_s) begin
            state_d = HUNT;
            slot_d  = SLOT_ZERO;
            miss_d  = MISS_ZERO;
          end else if (sync) begin
            // Realign on the misplaced pulse and drop the partial frame.
            miss_d = miss_q + MISS_ONE;
            slot_d = SLOT_ONE;
            clr_s  = 1'b1;
            en1_s  = 1'b1;
          end else begin
            // Missing sync: keep capturing on the free-running slot count.
            miss_d = miss_q + MISS_ONE;
            slot_d = SLOT_ONE;
            en1_s  = 1'b1;
          end
        end else begin
          if (sync) begin
            miss_d = MISS_ZERO;
          end else begin
            miss_d = miss_q;
          end
          en1_s = ~slot_q[0];
          en2_s = slot_q[0];
          if (slot_q == SLOT_LAST) begin
            slot_d       = SLOT_ZERO;
            word1_d      = ch1_next_s;
            word2_d      = ch2_next_s;
            word_valid_d = 1'b1;
          end else begin
            slot_d = slot_q + SLOT_ONE;
          end
        end
      end
      default: begin
        state_d = HUNT;
        slot_d  = SLOT_ZERO;
        miss_d  = MISS_ZERO;
      end
    endcase
    lock_d = (state_d == LOCK);
  end

  // State and registered outputs, cleared asynchronously by the active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= HUNT;
      slot_q       <= SLOT_ZERO;
      miss_q       <= MISS_ZERO;
      word1_q      <= {WORD_W{1'b0}};
      word2_q      <= {WORD_W{1'b0}};
      word_valid_q <= 1'b0;
      lock_q       <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      miss_q       <= miss_d;
      word1_q      <= word1_d;
      word2_q      <= word2_d;
      word_valid_q <= word_valid_d;
      lock_q       <= lock_d;
      sync_err_q   <= sync_err_d;
    end
  end

  ts_shift_collect #(.WORD_W(WORD_W)) u_ch1 (
    .clk       (clk),
    .rst       (rst),
    .en        (en1_s),
    .clr       (clr_s),
    .bit_in    (din),
    .data_next (ch1_next_s)
  );

  ts_shift_collect #(.WORD_W(WORD_W)) u_ch2 (
    .clk       (clk),
    .rst       (rst),
    .en        (en2_s),
    .clr       (clr_s),
    .bit_in    (din),
    .data_next (ch2_next_s)
  );

  assign word1      = word1_q;
  assign word2      = word2_q;
  assign word_valid = word_valid_q;
  assign lock       = lock_q;
  assign slot       = slot_q;
  assign sync_err   = sync_err_q;

`ifdef DEMUX_ERRCNT_EN
  logic [ERRCNT_W-1:0] err_count_q, err_count_d;

  // Saturating count of sync-error pulses.
  always_comb begin
    if (sync_err_d && (err_count_q != {ERRCNT_W{1'b1}})) begin
      err_count_d = err_count_q + ERRCNT_W'(1);
    end else begin
      err_count_d = err_count_q;
    end
  end

  // Error counter register; only reset clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_count_q <= {ERRCNT_W{1'b0}};
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_timeshared_demux_deser.sv
// Self-checking bench for timeshared_demux_deser (WORD_W=4, SYNC_MISS_MAX=2).
module tb_timeshared_demux_deser;

  localparam int WORD_W        = 4;
  localparam int SYNC_MISS_MAX = 2;
  localparam int FRAME         = 2 * WORD_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              din;
  logic              sync;
  logic [WORD_W-1:0] word1;
  logic [WORD_W-1:0] word2;
  logic              word_valid;
  logic              lock;
  logic [2:0]        slot;
  logic              sync_err;
`ifdef DEMUX_ERRCNT_EN
  logic [7:0]        err_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  timeshared_demux_deser #(.WORD_W(WORD_W), .SYNC_MISS_MAX(SYNC_MISS_MAX)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .sync       (sync),
    .word1      (word1),
    .word2      (word2),
    .word_valid (word_valid),
    .lock       (lock),
    .slot       (slot),
    .sync_err   (sync_err)
`ifdef DEMUX_ERRCNT_EN
    ,
    .err_count  (err_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: frame position, bit array, miss count, expected outputs.
  logic              m_lock;
  int                m_pos;
  int                m_miss;
  int                m_err;
  logic              m_bits [FRAME];
  logic [WORD_W-1:0] m_w1, m_w2;
  logic              m_wv, m_se;

  task automatic model_reset();
    m_lock = 1'b0; m_pos = 0; m_miss = 0; m_err = 0;
    m_w1 = '0; m_w2 = '0; m_wv = 1'b0; m_se = 1'b0;
    for (int i = 0; i < FRAME; i++) m_bits[i] = 1'b0;
  endtask

  task automatic model_edge(input logic s, input logic d);
    bit bad;
    m_wv = 1'b0;
    m_se = 1'b0;
    if (!m_lock) begin
      if (s) begin
        m_lock = 1'b1; m_pos = 1; m_miss = 0; m_bits[0] = d;
      end
    end else begin
      bad = (s && m_pos != 0) || (!s && m_pos == 0);
      if (bad) begin
        m_se = 1'b1;
        m_miss++;
        if (m_err < 255) m_err++;
      end
      if (bad && m_miss >= SYNC_MISS_MAX) begin
        m_lock = 1'b0; m_pos = 0; m_miss = 0;
      end else if (s && m_pos != 0) begin
        m_bits[0] = d; m_pos = 1;
      end else begin
        if (s) m_miss = 0;
        m_bits[m_pos] = d;
        if (m_pos == FRAME - 1) begin
          for (int i = 0; i < WORD_W; i++) begin
            m_w1[i] = m_bits[2*i];
            m_w2[i] = m_bits[2*i+1];
          end
          m_wv  = 1'b1;
          m_pos = 0;
        end else begin
          m_pos++;
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("word1", 32'(word1), 32'(m_w1));
    chk("word2", 32'(word2), 32'(m_w2));
    chk("word_valid", 32'(word_valid), 32'(m_wv));
    chk("lock", 32'(lock), 32'(m_lock));
    chk("slot", 32'(slot), 32'(m_pos));
    chk("sync_err", 32'(sync_err), 32'(m_se));
`ifdef DEMUX_ERRCNT_EN
    chk("err_count", 32'(err_count), 32'(m_err));
`endif
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_word1"}, 32'(word1), 32'd0);
    chk({tag, "_word2"}, 32'(word2), 32'd0);
    chk({tag, "_word_valid"}, 32'(word_valid), 32'd0);
    chk({tag, "_lock"}, 32'(lock), 32'd0);
    chk({tag, "_slot"}, 32'(slot), 32'd0);
    chk({tag, "_sync_err"}, 32'(sync_err), 32'd0);
  endtask

  // Drive inputs just after an edge, take the next edge, update the model.
  task automatic step(input logic s, input logic d);
    sync = s;
    din  = d;
    @(posedge clk);
    model_edge(s, d);
    #1;
  endtask

  task automatic stepc(input logic s, input logic d);
    step(s, d);
    check_model();
  endtask

  task automatic do_reset();
    rst = 1'b0; sync = 1'b0; din = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       s;
    logic       d;
    logic [3:0] w1;
    logic [3:0] w2;
    logic       wv;
    logic       lk;
    logic [2:0] sl;
    logic       se;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wv_hits;
    int first_wv;
    int last_wv;
    int se_hits;

    // Basic frame: slots 0..7 = 0,1,1,1,0,0,1,0 -> word1=A, word2=3.
    vecs[0] = '{1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 3'd1, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b1, 3'd2, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b1, 3'd3, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b1, 3'd4, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 3'd5, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 3'd6, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b1, 3'd7, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 4'hA, 4'h3, 1'b1, 1'b1, 3'd0, 1'b0};
    vecs[8] = '{1'b1, 1'b1, 4'hA, 4'h3, 1'b0, 1'b1, 3'd1, 1'b0};
    vecs[9] = '{1'b0, 1'b0, 4'hA, 4'h3, 1'b0, 1'b1, 3'd2, 1'b0};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(vecs[i].s, vecs[i].d);
      chk($sformatf("tbl%0d_word1", i), 32'(word1), 32'(vecs[i].w1));
      chk($sformatf("tbl%0d_word2", i), 32'(word2), 32'(vecs[i].w2));
      chk($sformatf("tbl%0d_word_valid", i), 32'(word_valid), 32'(vecs[i].wv));
      chk($sformatf("tbl%0d_lock", i), 32'(lock), 32'(vecs[i].lk));
      chk($sformatf("tbl%0d_slot", i), 32'(slot), 32'(vecs[i].sl));
      chk($sformatf("tbl%0d_sync_err", i), 32'(sync_err), 32'(vecs[i].se));
    end

    // Continuous frames: three word_valid pulses 8 cycles apart, no sync_err.
    do_reset();
    stepc(1'b1, 1'($urandom_range(0, 1)));
    wv_hits = 0; first_wv = -1; last_wv = -1; se_hits = 0;
    for (int k = 1; k <= 24; k++) begin
      stepc((k % FRAME) == 0, 1'($urandom_range(0, 1)));
      if (word_valid) begin
        if (wv_hits > 0) chk("cont_spacing", 32'(k - last_wv), 32'(FRAME));
        if (wv_hits == 0) first_wv = k;
        wv_hits++;
        last_wv = k;
      end
      if (sync_err) se_hits++;
    end
    chk("cont_wv_count", 32'(wv_hits), 32'd3);
    chk("cont_first_wv", 32'(first_wv), 32'd7);
    chk("cont_sync_err", 32'(se_hits), 32'd0);

    // Missing sync twice: first keeps lock, second drops to HUNT.
    do_reset();
    stepc(1'b1, 1'b1);
    for (int k = 0; k < 7; k++) stepc(1'b0, 1'($urandom_range(0, 1)));
    stepc(1'b0, 1'b1);
    chk("miss1_sync_err", 32'(sync_err), 32'd1);
    chk("miss1_lock", 32'(lock), 32'd1);
    for (int k = 0; k < 7; k++) stepc(1'b0, 1'($urandom_range(0, 1)));
    chk("miss1_frame_wv", 32'(word_valid), 32'd1);
    stepc(1'b0, 1'b0);
    chk("miss2_sync_err", 32'(sync_err), 32'd1);
    chk("miss2_lock", 32'(lock), 32'd0);
    chk("miss2_slot", 32'(slot), 32'd0);

    // Misplaced sync at slot 5: frame dropped, next word 8 cycles later.
    do_reset();
    stepc(1'b1, 1'b0);
    for (int k = 0; k < 4; k++) stepc(1'b0, 1'($urandom_range(0, 1)));
    chk("mis5_slot_before", 32'(slot), 32'd5);
    stepc(1'b1, 1'b1);
    chk("mis5_sync_err", 32'(sync_err), 32'd1);
    chk("mis5_slot_after", 32'(slot), 32'd1);
    wv_hits = 0; first_wv = -1;
    for (int k = 1; k <= 8; k++) begin
      stepc(1'b0, 1'($urandom_range(0, 1)));
      if (word_valid && first_wv < 0) first_wv = k;
    end
    chk("mis5_next_wv_step", 32'(first_wv), 32'd7);

    // Misplaced sync on the last slot: no word_valid for the broken frame.
    do_reset();
    stepc(1'b1, 1'b1);
    for (int k = 0; k < 6; k++) stepc(1'b0, 1'($urandom_range(0, 1)));
    chk("mis7_slot_before", 32'(slot), 32'd7);
    stepc(1'b1, 1'b0);
    chk("mis7_word_valid", 32'(word_valid), 32'd0);
    chk("mis7_sync_err", 32'(sync_err), 32'd1);
    chk("mis7_word1_held", 32'(word1), 32'd0);

    // Asynchronous reset between edges at slot 3.
    do_reset();
    stepc(1'b1, 1'b1);
    stepc(1'b0, 1'b1);
    stepc(1'b0, 1'b1);
    chk("arst_slot_before", 32'(slot), 32'd3);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_all_zero("arst_now");
    @(posedge clk);
    #1;
    check_all_zero("arst_held");
    #2;
    rst = 1'b1;
    for (int k = 0; k < 10; k++) stepc(1'b0, 1'($urandom_range(0, 1)));
    stepc(1'b1, 1'b0);
    for (int k = 0; k < 9; k++) stepc(1'b0, 1'($urandom_range(0, 1)));

    // Randomised traffic: mostly aligned syncs with stray and dropped pulses.
    do_reset();
    for (int k = 0; k < 2500; k++) begin
      if ((k % FRAME) == 0) stepc(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)));
      else stepc(1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 1)));
    end

`ifdef DEMUX_ERRCNT_EN
    // 300 misplaced syncs with a correct sync between each: counter saturates.
    do_reset();
    for (int e = 0; e < 300; e++) begin
      stepc(1'b1, 1'($urandom_range(0, 1)));
      stepc(1'b0, 1'($urandom_range(0, 1)));
      stepc(1'b0, 1'($urandom_range(0, 1)));
      stepc(1'b1, 1'($urandom_range(0, 1)));
      for (int k = 0; k < 7; k++) stepc(1'b0, 1'($urandom_range(0, 1)));
    end
    chk("errcnt_saturated", 32'(err_count), 32'hFF);
    chk("errcnt_lock", 32'(lock), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/timeshared_demux_deser.md
Name: timeshared_demux_deser

Overview:
- Downstream stage of the time-shared clock-edge multiplexer. Consumes the single interleaved serial line, where even slots carry channel 1 and odd slots carry channel 2, plus a frame-sync pulse.
- Splits the stream back into two channels and deserialises each into WORD_W-bit words.
- Tracks frame alignment with a HUNT/LOCK state machine and a sync-miss counter.

Parameters:
- WORD_W, 4, bits per channel word. Frame length is 2*WORD_W clock cycles. Legal range is WORD_W >= 2.
- SYNC_MISS_MAX, 2, consecutive sync errors tolerated in LOCK before dropping to HUNT. Legal range is >= 1.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset; all state clears immediately while low
- din  in  1  interleaved serial data from the mux stage
- sync  in  1  high in the cycle din carries channel-1 bit 0 of a frame
- word1  out  WORD_W  last complete channel-1 word
- word2  out  WORD_W  last complete channel-2 word
- word_valid  out  1  one-cycle pulse when word1/word2 update
- lock  out  1  high while in LOCK
- slot  out  $clog2(2*WORD_W)  current frame slot (0 in HUNT)
- sync_err  out  1  one-cycle pulse on a missing or misplaced sync

Behaviour:
- Reset (rst=0):
  - state=HUNT.
  - slot, both shift registers, word1, word2, word_valid, lock, sync_err and the miss counter all go to 0.
  - A partial frame in progress is discarded.
- HUNT:
  - din is ignored while sync=0.
  - When sync=1, din is captured as channel-1 bit 0, slot becomes 1, the miss counter clears, and the state moves to LOCK. lock=1 from the next cycle.
- LOCK, slot handling:
  - Even slot s: din goes to channel-1 bit s/2.
  - Odd slot s: din goes to channel-2 bit (s-1)/2.
  - Bits are collected LSB first.
  - slot increments each cycle and wraps from 2*WORD_W-1 to 0.
- LOCK, word output:
  - In the cycle after the slot-(2*WORD_W-1) bit is sampled, word1 and word2 hold the complete words and word_valid=1 for exactly that one cycle.
  - Words hold their value until the next update.
- LOCK, sync at slot 0 (expected):
  - sync=1 clears the miss counter.
  - sync=0 asserts sync_err and increments the miss counter, but capture continues on the free-running slot count.
- LOCK, sync=1 at any slot other than 0 (misplaced):
  - sync_err asserts and the miss counter increments.
  - The partial frame is discarded; no word_valid is produced for it, including when the misplaced sync lands on slot 2*WORD_W-1.
  - din is captured as the new channel-1 bit 0 and slot becomes 1.
- LOCK, loss of lock:
  - When the miss counter reaches SYNC_MISS_MAX, the state returns to HUNT on that edge and lock falls next cycle.
  - The triggering sync pulse is not used for realignment; a fresh sync is required.
- Simultaneous events: word_valid for a completed frame and a correct sync at slot 0 in the same cycle are both honoured.
- sync_err and word_valid are never asserted in HUNT.

Optional Feature:
- Macro DEMUX_ERRCNT_EN.
- Defined: adds output port err_count (8 bits). It increments on every sync_err pulse, saturates at 8'hFF, and is cleared only by reset.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package timeshared_pkg holds:
  - the state typedef (HUNT=0, LOCK=1),
  - the ERRCNT_W=8 constant,
  - a helper function for slot width, $clog2(2*WORD_W).
- One sub-module, ts_shift_collect: a WORD_W-bit LSB-first shift collector with enable and clear, instantiated once per channel.

Test Plan (all scenarios use WORD_W=4, SYNC_MISS_MAX=2):
- Basic frame: after reset, sync at the first bit; stream slots 0..7 = 0,1,1,1,0,0,1,0 → word1=4'hA, word2=4'h3, word_valid high exactly 1 cycle after slot 7, lock=1 from the cycle after sync.
- Continuous frames: three back-to-back frames with sync every 8 cycles → three word_valid pulses spaced 8 cycles apart, sync_err never asserted.
- Missing sync: omit one sync at slot 0 → sync_err pulse, frame still decoded, lock stays 1. Omit the next one too → lock=0 next cycle, state HUNT.
- Misplaced sync: sync=1 at slot 5 → sync_err pulse, no word_valid for the broken frame, next word_valid 8 cycles after the misplaced sync.
- Async reset mid-frame: assert rst=0 at slot 3 between clock edges → all outputs 0 immediately. After release, no word_valid until a new sync and a full frame.
- DEMUX_ERRCNT_EN defined: 300 misplaced-sync events with realignment (a correct sync every other frame) → err_count saturates at 8'hFF.
